// File: rtl/display_mode_switcher_pkg.sv
// Shared definitions for the display mode switcher: default widths, blank levels,
// source index names and the FSM state type.
package display_mode_switcher_pkg;

    localparam int unsigned DEF_NUM_SRC = 3;
    localparam int unsigned DEF_LED_W   = 16;
    localparam int unsigned DEF_AN_W    = 4;
    localparam int unsigned DEF_SEG_W   = 7;
    localparam int unsigned DEF_OLED_W  = 16;

    // Blank levels: black pixels, all anodes and segments off (active-low)
    localparam logic [DEF_OLED_W-1:0] BLACK   = '0;
    localparam logic [DEF_AN_W-1:0]   CLR_AN  = '1;
    localparam logic [DEF_SEG_W-1:0]  CLR_SEG = '1;

    localparam int unsigned SRC_GAME = 0;
    localparam int unsigned SRC_WAVE = 1;
    localparam int unsigned SRC_VOL  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StActive
    } state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_mode_switcher_sel_debouncer.sv
// Synchronises the select and freeze switches, priority-encodes the select and
// reports when the encoded request has been steady long enough to act on.
module display_mode_switcher_sel_debouncer
    import display_mode_switcher_pkg::*;
#(
    parameter int unsigned NUM_SRC       = DEF_NUM_SRC,
    parameter int unsigned STABLE_CYCLES = 100000,
    parameter int unsigned IDX_W         = idx_width(NUM_SRC)
) (
    input  logic               basys_clock,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] sel_sw,
    input  logic               freeze,
    output logic [IDX_W-1:0]   cand_idx,
    output logic               stable,
    output logic               freeze_sync
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [NUM_SRC-1:0] sel_meta_q, sel_sync_q;
    logic               freeze_meta_q, freeze_sync_q;
    logic [IDX_W-1:0]   req_idx;
    logic               req_valid;
    logic [IDX_W-1:0]   cand_idx_q;
    logic               cand_valid_q;
    logic [CNT_W-1:0]   stable_cnt_q;

    always_ff @(posedge basys_clock or negedge rstn) begin
        if (!rstn) begin
            sel_meta_q    <= '0;
            sel_sync_q    <= '0;
            freeze_meta_q <= 1'b0;
            freeze_sync_q <= 1'b0;
        end else begin
            sel_meta_q    <= sel_sw;
            sel_sync_q    <= sel_meta_q;
            freeze_meta_q <= freeze;
            freeze_sync_q <= freeze_meta_q;
        end
    end

    // Ascending scan so the highest set index is the one left standing
    always_comb begin
        req_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_sync_q[i]) begin
                req_idx = IDX_W'(i);
            end
        end
        req_valid = |sel_sync_q;
    end

    always_ff @(posedge basys_clock or negedge rstn) begin
        if (!rstn) begin
            cand_idx_q   <= '0;
            cand_valid_q <= 1'b0;
            stable_cnt_q <= '0;
        end else if ({req_valid, req_idx} != {cand_valid_q, cand_idx_q}) begin
            cand_idx_q   <= req_idx;
            cand_valid_q <= req_valid;
            stable_cnt_q <= '0;
        end else if (stable_cnt_q != CNT_MAX) begin
            stable_cnt_q <= stable_cnt_q + CNT_W'(1);
        end
    end

    assign cand_idx    = cand_idx_q;
    assign stable      = cand_valid_q && (stable_cnt_q == CNT_MAX);
    assign freeze_sync = freeze_sync_q;

endmodule

// File: rtl/display_mode_switcher.sv
// Routes one of NUM_SRC display sources to the board outputs, blanking the panel
// for BLANK_CYCLES on every change of source, with an optional per-source LED freeze.
module display_mode_switcher
    import display_mode_switcher_pkg::*;
#(
    parameter int unsigned NUM_SRC       = DEF_NUM_SRC,
    parameter int unsigned LED_W         = DEF_LED_W,
    parameter int unsigned AN_W          = DEF_AN_W,
    parameter int unsigned SEG_W         = DEF_SEG_W,
    parameter int unsigned OLED_W        = DEF_OLED_W,
    parameter int unsigned STABLE_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter logic [NUM_SRC-1:0] FREEZE_MASK = NUM_SRC'((1 << SRC_VOL) | (1 << SRC_WAVE)),
    localparam int unsigned IDX_W        = idx_width(NUM_SRC)
) (
    input  logic                      basys_clock,
    input  logic                      rstn,
    input  logic [NUM_SRC-1:0]        sel_sw,
    input  logic                      freeze,
    input  logic [NUM_SRC*LED_W-1:0]  led_src,
    input  logic [NUM_SRC*AN_W-1:0]   an_src,
    input  logic [NUM_SRC*SEG_W-1:0]  seg_src,
    input  logic [NUM_SRC*OLED_W-1:0] oled_src,
    output logic [LED_W-1:0]          led,
    output logic [AN_W-1:0]           an,
    output logic [SEG_W-1:0]          seg,
    output logic [OLED_W-1:0]         oled_data,
    output logic [IDX_W-1:0]          active_idx,
    output logic                      active_valid,
    output logic                      mode_changed
);

    localparam int unsigned      BC_W       = idx_width(BLANK_CYCLES);
    localparam logic [BC_W-1:0]  BLANK_LAST = BC_W'(BLANK_CYCLES - 1);

    localparam logic [AN_W-1:0]   AN_OFF    = {AN_W{CLR_AN[0]}};
    localparam logic [SEG_W-1:0]  SEG_OFF   = {SEG_W{CLR_SEG[0]}};
    localparam logic [OLED_W-1:0] OLED_OFF  = {OLED_W{BLACK[0]}};

    logic [IDX_W-1:0] cand_idx;
    logic             stable;
    logic             freeze_sync;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] target_q, target_d;
    logic [BC_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic [IDX_W-1:0] active_idx_q, active_idx_d;
    logic             mode_changed_q, mode_changed_d;

    logic [LED_W-1:0]  led_sel, led_q;
    logic [AN_W-1:0]   an_sel, an_q;
    logic [SEG_W-1:0]  seg_sel, seg_q;
    logic [OLED_W-1:0] oled_sel, oled_q;
    logic              led_frozen;

    display_mode_switcher_sel_debouncer #(
        .NUM_SRC       (NUM_SRC),
        .STABLE_CYCLES (STABLE_CYCLES),
        .IDX_W         (IDX_W)
    ) u_sel_debouncer (
        .basys_clock (basys_clock),
        .rstn        (rstn),
        .sel_sw      (sel_sw),
        .freeze      (freeze),
        .cand_idx    (cand_idx),
        .stable      (stable),
        .freeze_sync (freeze_sync)
    );

    always_ff @(posedge basys_clock or negedge rstn) begin
        if (!rstn) begin
            state_q        <= StIdle;
            target_q       <= '0;
            blank_cnt_q    <= '0;
            active_idx_q   <= IDX_W'(SRC_GAME);
            mode_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            blank_cnt_q    <= blank_cnt_d;
            active_idx_q   <= active_idx_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        blank_cnt_d    = blank_cnt_q;
        active_idx_d   = active_idx_q;
        mode_changed_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (stable) begin
                    state_d     = StBlank;
                    target_d    = cand_idx;
                    blank_cnt_d = '0;
                end
            end
            StBlank: begin
                // A newer settled request restarts the full blank interval
                if (stable && (cand_idx != target_q)) begin
                    target_d    = cand_idx;
                    blank_cnt_d = '0;
                end else if (blank_cnt_q == BLANK_LAST) begin
                    state_d        = StActive;
                    active_idx_d   = target_q;
                    mode_changed_d = 1'b1;
                end else begin
                    blank_cnt_d = blank_cnt_q + BC_W'(1);
                end
            end
            StActive: begin
                if (stable && (cand_idx != active_idx_q)) begin
                    state_d     = StBlank;
                    target_d    = cand_idx;
                    blank_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        led_sel    = '0;
        an_sel     = AN_OFF;
        seg_sel    = SEG_OFF;
        oled_sel   = OLED_OFF;
        led_frozen = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_idx_q == IDX_W'(i)) begin
                led_sel    = led_src[i*LED_W +: LED_W];
                an_sel     = an_src[i*AN_W +: AN_W];
                seg_sel    = seg_src[i*SEG_W +: SEG_W];
                oled_sel   = oled_src[i*OLED_W +: OLED_W];
                led_frozen = freeze_sync && FREEZE_MASK[i];
            end
        end
    end

    // Freeze only matters while live; idle and blank always force the blank levels
    always_ff @(posedge basys_clock or negedge rstn) begin
        if (!rstn) begin
            led_q  <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            oled_q <= OLED_OFF;
        end else if (state_q == StActive) begin
            if (!led_frozen) begin
                led_q <= led_sel;
            end
            an_q   <= an_sel;
            seg_q  <= seg_sel;
            oled_q <= oled_sel;
        end else begin
            led_q  <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            oled_q <= OLED_OFF;
        end
    end

    assign led          = led_q;
    assign an           = an_q;
    assign seg          = seg_q;
    assign oled_data    = oled_q;
    assign active_idx   = active_idx_q;
    assign active_valid = (state_q == StActive);
    assign mode_changed = mode_changed_q;

endmodule
